// File: rtl/vram_tile_ctrl.sv
// vram_tile_ctrl: ROWS x COLS tile/character RAM for the VGA subsystem.
// One CPU write/read port, one scan-out read port (both reads registered,
// read-first), and a clear engine that fills one cell per cycle.
// Optional feature macro: VRAM_BYTE_WE_EN (honour cpu_be on CPU writes).
// Handshake: cpu_rd/scan_en are single-cycle requests with no back-pressure;
// the response appears exactly one cycle later (cpu_rvalid qualifies
// cpu_rdata, scan_data simply updates when scan_en was high).
module vram_tile_ctrl #(
    parameter int DATA_W  = 16,
    parameter int COLS    = 8,
    parameter int ROWS    = 6,
    parameter int ADDR_W  = 9,
    parameter int SADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    input  logic                cpu_rd,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_rvalid,
    input  logic                scan_en,
    input  logic [SADDR_W-1:0]  scan_addr,
    output logic [DATA_W-1:0]   scan_data,
    input  logic                clr_req,
    input  logic [DATA_W-1:0]   clr_data,
    output logic                busy,
    output logic                clr_done,
    output logic                oob_err
);
    localparam int DEPTH = ROWS * COLS;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB    = DATA_W / 8;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state, state_next;
    logic [IDX_W-1:0]  ptr, ptr_next;
    logic [DATA_W-1:0] clr_val, clr_val_next;
    logic              clr_last;
    logic              done_pend;

    logic              cpu_in, scan_in, cpu_wr;
    logic [IDX_W-1:0]  cpu_idx, scan_idx;
    logic [DATA_W-1:0] wr_word;

    // Each port checks only its own address against the array size.
    assign cpu_in   = cpu_addr < ADDR_W'(DEPTH);
    assign scan_in  = scan_addr < SADDR_W'(DEPTH);
    assign cpu_idx  = cpu_addr[IDX_W-1:0];
    assign scan_idx = scan_addr[IDX_W-1:0];
    // CPU writes are only accepted while the clear engine is idle.
    assign cpu_wr   = (state == IDLE) && cpu_we && cpu_in;
    assign busy     = (state == CLEAR);

`ifdef VRAM_BYTE_WE_EN
    // Merge enabled bytes of the new data over the current cell contents.
    always_comb begin
        wr_word = mem[cpu_idx];
        for (int b = 0; b < NB; b++) begin
            if (cpu_be[b]) wr_word[8*b +: 8] = cpu_wdata[8*b +: 8];
        end
    end
`else
    logic unused_be;
    assign unused_be = ^cpu_be;
    // Full-word writes: byte enables play no part in this build.
    always_comb begin
        wr_word = cpu_wdata;
    end
`endif

    // Clear engine next-state: walk ptr from 0 to DEPTH-1, one cell per cycle.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        clr_val_next = clr_val;
        clr_last     = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next   = CLEAR;
                    ptr_next     = '0;
                    clr_val_next = clr_data;
                end
            end
            CLEAR: begin
                if (ptr == LAST) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                    clr_last   = 1'b1;
                end else begin
                    ptr_next = ptr + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Clear engine registers; clr_done trails the fall of busy by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            clr_val   <= '0;
            done_pend <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            clr_val   <= clr_val_next;
            done_pend <= clr_last;
            clr_done  <= done_pend;
        end
    end

    // Cell array: reset zeroes everything, the clear engine owns it while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == CLEAR) begin
            mem[ptr] <= clr_val;
        end else if (cpu_wr) begin
            mem[cpu_idx] <= wr_word;
        end
    end

    // Registered read ports (read-first) and the out-of-range error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            scan_data  <= '0;
            oob_err    <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_rd;
            if (cpu_rd) cpu_rdata <= cpu_in ? mem[cpu_idx] : '0;
            if (scan_en) scan_data <= scan_in ? mem[scan_idx] : '0;
            oob_err <= !cpu_in && (cpu_rd || (cpu_we && state == IDLE));
        end
    end

endmodule

// File: tb/tb_vram_tile_ctrl.sv
// tb_vram_tile_ctrl: randomized and directed stimulus for vram_tile_ctrl,
// checked against a cell-array reference model through stamped queues.
module tb_vram_tile_ctrl;
    localparam int DEPTH = 48;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        cpu_we, cpu_rd, scan_en, clr_req;
    logic [8:0]  cpu_addr;
    logic [15:0] cpu_wdata, clr_data;
    logic [1:0]  cpu_be;
    logic [5:0]  scan_addr;
    logic [15:0] cpu_rdata, scan_data;
    logic        cpu_rvalid, busy, clr_done, oob_err;

    vram_tile_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .scan_en(scan_en), .scan_addr(scan_addr), .scan_data(scan_data),
        .clr_req(clr_req), .clr_data(clr_data),
        .busy(busy), .clr_done(clr_done), .oob_err(oob_err)
    );

    // reference model and scoreboard
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model [DEPTH];
    int          edge_n = 0;
    bit          clr_on = 1'b0;
    int          k0 = 0;
    logic [15:0] clr_v = '0;
    logic [15:0] last_scan = '0;

    logic [15:0] exp_q[$];      // expected cpu_rdata
    int          exp_k_q[$];    // edge at which each cpu read is sampled
    logic [15:0] scan_q[$];
    int          scan_k_q[$];
    int          oob_k_q[$];
    int          done_k_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // driver: one call = one clock edge worth of stimulus
    task automatic step(input logic we, input logic rd, input logic [8:0] addr,
                        input logic [15:0] wd, input logic [1:0] be,
                        input logic sen, input logic [5:0] sa,
                        input logic creq, input logic [15:0] cd);
        int k;
        bit in_clear;
        bit a_ok;
        k = edge_n + 1;
        cpu_we = we; cpu_rd = rd; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
        scan_en = sen; scan_addr = sa; clr_req = creq; clr_data = cd;
        a_ok = (addr < 9'(DEPTH));
        in_clear = clr_on && (k >= k0 + 1) && (k <= k0 + DEPTH);
        // reads observe the array before this edge's writes
        if (rd) begin
            exp_q.push_back(a_ok ? model[addr[5:0]] : 16'h0000);
            exp_k_q.push_back(k);
        end
        if (sen) begin
            scan_q.push_back((sa < 6'(DEPTH)) ? model[sa] : 16'h0000);
            scan_k_q.push_back(k);
        end
        if (!a_ok && (rd || (we && !in_clear))) oob_k_q.push_back(k);
        if (in_clear) begin
            model[k - k0 - 1] = clr_v;
        end else if (we && a_ok) begin
`ifdef VRAM_BYTE_WE_EN
            if (be[0]) model[addr[5:0]][7:0]  = wd[7:0];
            if (be[1]) model[addr[5:0]][15:8] = wd[15:8];
`else
            model[addr[5:0]] = wd;
`endif
        end
        if (creq && !in_clear) begin
            clr_on = 1'b1;
            k0 = k;
            clr_v = cd;
            done_k_q.push_back(k + DEPTH + 1);
        end
        @(posedge clk);
        edge_n = k;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 9'd0, 16'h0, 2'b00, 0, 6'd0, 0, 16'h0);
    endtask

    task automatic scan_all();
        for (int i = 0; i < DEPTH; i++) step(0, 0, 9'd0, 16'h0, 2'b00, 1, 6'(i), 0, 16'h0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) step(0, 1, 9'(i), 16'h0, 2'b00, 0, 6'd0, 0, 16'h0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
        chk({tag, "_scan_data"}, scan_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_clr_done"}, clr_done, 0);
        chk({tag, "_oob_err"}, oob_err, 0);
    endtask

    task automatic apply_reset(input string tag);
        idle(1);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
        clr_on = 1'b0;
        exp_q.delete(); exp_k_q.delete(); scan_q.delete(); scan_k_q.delete();
        oob_k_q.delete(); done_k_q.delete();
        last_scan = 16'h0000;
        #2;
        check_reset_values(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // monitor: compares DUT outputs on the falling edge after each active edge
    always @(negedge clk) begin
        if (!rst) begin
            int k;
            bit e;
            logic [15:0] d;
            k = edge_n;
            if (exp_k_q.size() > 0 && exp_k_q[0] == k) begin
                void'(exp_k_q.pop_front());
                d = exp_q.pop_front();
                chk("cpu_rvalid", cpu_rvalid, 1);
                chk("cpu_rdata", cpu_rdata, d);
            end else begin
                chk("cpu_rvalid_idle", cpu_rvalid, 0);
            end
            if (scan_k_q.size() > 0 && scan_k_q[0] == k) begin
                void'(scan_k_q.pop_front());
                last_scan = scan_q.pop_front();
                chk("scan_data", scan_data, last_scan);
            end else begin
                chk("scan_hold", scan_data, last_scan);
            end
            e = (oob_k_q.size() > 0 && oob_k_q[0] == k);
            if (e) void'(oob_k_q.pop_front());
            chk("oob_err", oob_err, e);
            e = (done_k_q.size() > 0 && done_k_q[0] == k);
            if (e) void'(done_k_q.pop_front());
            chk("clr_done", clr_done, e);
            chk("busy", busy, clr_on && (k >= k0) && (k <= k0 + DEPTH - 1));
        end
    end

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        logic        r_we, r_rd, r_sen, r_creq;
        logic [8:0]  r_addr;
        logic [15:0] r_wd, r_cd;
        logic [1:0]  r_be;
        logic [5:0]  r_sa;

        rst = 1'b1;
        cpu_we = 0; cpu_rd = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        scan_en = 0; scan_addr = '0; clr_req = 0; clr_data = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // every cell reads zero after reset, out-of-range scan reads zero
        scan_all();
        step(0, 0, 9'd0, 16'h0, 2'b00, 1, 6'd50, 0, 16'h0);
        step(0, 0, 9'd0, 16'h0, 2'b00, 1, 6'd63, 0, 16'h0);

        // top cell write/read, out-of-range write/read, combined we+rd oob
        step(1, 0, 9'd47, 16'hBEEF, 2'b11, 0, 6'd0, 0, 16'h0);
        step(0, 1, 9'd47, 16'h0, 2'b00, 0, 6'd0, 0, 16'h0);
        step(1, 0, 9'd48, 16'h1111, 2'b11, 0, 6'd0, 0, 16'h0);
        step(0, 1, 9'd48, 16'h0, 2'b00, 0, 6'd0, 0, 16'h0);
        step(1, 1, 9'd300, 16'h2222, 2'b11, 0, 6'd0, 0, 16'h0);
        idle(1);
        scan_all();

        // read-first on the scan port
        step(1, 0, 9'd5, 16'h1234, 2'b11, 1, 6'd5, 0, 16'h0);
        step(0, 0, 9'd0, 16'h0, 2'b00, 1, 6'd5, 0, 16'h0);
        // read-first on the CPU port
        step(1, 1, 9'd6, 16'h4321, 2'b11, 0, 6'd0, 0, 16'h0);
        step(0, 1, 9'd6, 16'h0, 2'b00, 0, 6'd0, 0, 16'h0);

        // byte-enable merge
        step(1, 0, 9'd3, 16'hAAAA, 2'b11, 0, 6'd0, 0, 16'h0);
        step(1, 0, 9'd3, 16'h5555, 2'b01, 0, 6'd0, 0, 16'h0);
        step(0, 1, 9'd3, 16'h0, 2'b00, 1, 6'd3, 0, 16'h0);

        // full clear with a dropped CPU write and reads mid-clear
        step(0, 0, 9'd0, 16'h0, 2'b00, 0, 6'd0, 1, 16'h0F20);
        for (int i = 1; i < DEPTH; i++) begin
            if (i == 10)      step(1, 0, 9'd7, 16'hDEAD, 2'b11, 0, 6'd0, 0, 16'h0);
            else if (i == 20) step(0, 0, 9'd0, 16'h0, 2'b00, 0, 6'd0, 1, 16'h7777);
            else if (i == 30) step(0, 1, 9'd2, 16'h0, 2'b00, 1, 6'd40, 0, 16'h0);
            else if (i == 31) step(0, 1, 9'd60, 16'h0, 2'b00, 0, 6'd0, 0, 16'h0);
            else              idle(1);
        end
        idle(3);
        scan_all();
        read_all();

        // randomized traffic, including occasional clears
        for (int n = 0; n < 400; n++) begin
            r_we   = ($urandom_range(0, 2) == 0);
            r_rd   = ($urandom_range(0, 2) == 0);
            r_addr = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(48, 511)) : 9'($urandom_range(0, 47));
            r_wd   = 16'($urandom);
            r_be   = 2'($urandom_range(0, 3));
            r_sen  = 1'($urandom_range(0, 1));
            r_sa   = 6'($urandom_range(0, 63));
            r_creq = ($urandom_range(0, 79) == 0);
            r_cd   = 16'($urandom);
            step(r_we, r_rd, r_addr, r_wd, r_be, r_sen, r_sa, r_creq, r_cd);
        end
        idle(DEPTH + 3);

        // reset in the middle of a clear
        step(0, 0, 9'd0, 16'h0, 2'b00, 0, 6'd0, 1, 16'h1357);
        idle(19);
        apply_reset("midclr");
        idle(DEPTH + 3);
        scan_all();
        read_all();

        // drain and confirm nothing is left outstanding
        idle(4);
        chk("cpu_q_empty", exp_q.size(), 0);
        chk("scan_q_empty", scan_q.size(), 0);
        chk("oob_q_empty", oob_k_q.size(), 0);
        chk("done_q_empty", done_k_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_tile_ctrl.md
# vram_tile_ctrl

Parametrised tile/character video RAM controller for the VGA subsystem. It holds a ROWS×COLS array of DATA_W-bit cells written by the CPU store path and read by two independent read ports: the VGA scan-out port and the CPU load-back port. Both read ports have one cycle of registered latency. A hardware clear engine fills the whole array with a programmable value, one cell per cycle. Bounds checking applies to every port, and each port checks its own address.

## Interface
Parameters:
- DATA_W, 16, cell width in bits; must be a multiple of 8.
- COLS, 8, tiles per row.
- ROWS, 6, tile rows; DEPTH = ROWS*COLS (localparam).
- ADDR_W, 9, CPU-side address width; must satisfy 2^ADDR_W ≥ DEPTH.
- SADDR_W, 6, scan-side address width; must satisfy 2^SADDR_W ≥ DEPTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_we  in  1  CPU write strobe.
- cpu_addr  in  ADDR_W  CPU write/read address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_be  in  DATA_W/8  byte enables. Honoured only with VRAM_BYTE_WE_EN.
- cpu_rd  in  1  CPU read strobe.
- cpu_rdata  out  DATA_W  CPU read data, registered.
- cpu_rvalid  out  1  one-cycle pulse qualifying cpu_rdata.
- scan_en  in  1  scan read enable.
- scan_addr  in  SADDR_W  scan read address.
- scan_data  out  DATA_W  scan read data, registered.
- clr_req  in  1  clear request pulse.
- clr_data  in  DATA_W  fill value; sampled together with clr_req.
- busy  out  1  high while the clear engine is running.
- clr_done  out  1  one-cycle pulse when a clear completes.
- oob_err  out  1  one-cycle pulse on an out-of-range CPU access.

## Operation
- Memory reset: async rst zeroes all DEPTH cells.
- Output reset values: cpu_rdata=0, cpu_rvalid=0, scan_data=0, busy=0, clr_done=0, oob_err=0. FSM returns to IDLE.

FSM states:
- IDLE: clr_req=1 latches clr_data and goes to CLEAR with clear pointer=0.
- CLEAR: writes the latched value to cell[ptr] and increments ptr each cycle. When ptr reaches DEPTH-1, that write completes, the FSM returns to IDLE and clr_done pulses on the next cycle.
- clr_req while in CLEAR is ignored.

CPU write:
- In IDLE, cpu_we with cpu_addr<DEPTH writes the cell.
- cpu_addr≥DEPTH: no write, and oob_err pulses the following cycle.
- In CLEAR, CPU writes are dropped without error. Software polls busy.

CPU read:
- cpu_rd with cpu_addr<DEPTH: the next cycle gives cpu_rvalid=1 and cpu_rdata=cell.
- cpu_addr≥DEPTH: cpu_rvalid=1, cpu_rdata=0, oob_err=1.
- Reads are allowed during CLEAR.
- If cpu_we and cpu_rd are asserted together with an out-of-range address, oob_err is a single pulse.

Scan read:
- scan_en=1: scan_data ← cell[scan_addr] if scan_addr<DEPTH, else 0.
- scan_en=0: scan_data holds its value.
- The range check uses scan_addr only.

Read-during-write:
- Both read ports are read-first: a same-cycle write to the same cell returns the old data. This covers CPU writes and clear writes.

## Timing
- Write-to-cell: the write takes effect at the clock edge where cpu_we is sampled.
- Read latency: 1 cycle on both read ports.
- Clear duration: exactly DEPTH cycles of busy=1. busy rises on the edge that samples clr_req, and clr_done pulses one cycle after busy falls.
- Reset asserted mid-clear aborts the clear immediately. All cells read 0, and clr_done does not pulse.
- No combinational path from any input to any output.

## Configuration
- VRAM_BYTE_WE_EN defined: a CPU write updates only the bytes whose cpu_be bit is 1. cpu_be=0 counts as a legal no-op write, and its range check still applies.
- VRAM_BYTE_WE_EN undefined: cpu_be is ignored and every write updates the full DATA_W bits.
- The clear engine always writes full words in both builds.

## Test plan
All scenarios use the default parameters (DEPTH=48).
- Reset, then scan-read all 48 cells → scan_data=0x0000 each cycle after the address; scan_addr=50 → 0x0000.
- CPU write 0xBEEF to addr 47, then cpu_rd addr 47 → cpu_rvalid pulse with cpu_rdata=0xBEEF; write to addr 48 → oob_err pulse and no cell changes.
- Same-cycle cpu_we 0x1234 @5 and scan_en @5 (old 0x0000) → scan_data=0x0000; the next scan of @5 returns 0x1234.
- clr_req with clr_data=0x0F20 → busy high for exactly 48 cycles, then clr_done pulse. A cpu_we issued mid-clear is dropped, and every cell reads 0x0F20.
- Assert rst at clear cycle 20 → busy=0, clr_done stays 0, and cells 0–47 read 0x0000.
- VRAM_BYTE_WE_EN: cell=0xAAAA, then write 0x5555 with cpu_be=2'b01 → 0xAA55. Without the macro → 0x5555.
